// File: rtl/alu_issue_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer.
// Contents:
//   alu_op_e     - 2-bit ALU operation encodings (ADD, SUB, MUL, ILL)
//   seq_state_e  - sequencer FSM state encodings (IDLE, EXEC, DONE)
//   RD_WIDTH     - destination register tag width
//   op_issues    - true when a decoded op must be sent to the ALU
//   op_illegal   - true when a decoded op is the reserved encoding
package alu_issue_sequencer_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_MUL = 2'b10,
        ALU_OP_ILL = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_EXEC = 2'b01,
        SEQ_DONE = 2'b10
    } seq_state_e;

    localparam int RD_WIDTH = 5;

    // A NOP flag wins over the op field, so a NOP never issues and never
    // counts as illegal, whatever op bits come along with it.
    function automatic logic op_issues(input logic [1:0] op, input logic set_nop);
        return !set_nop && (op != ALU_OP_ILL);
    endfunction

    function automatic logic op_illegal(input logic [1:0] op, input logic set_nop);
        return !set_nop && (op == ALU_OP_ILL);
    endfunction

endpackage

// File: rtl/alu_issue_sequencer_counter.sv
// alu_latency_counter: down-counter that tracks the remaining ALU cycles of
// the op currently in execution.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous clear to 0 (highest priority)
//   load        - load load_value
//   load_value  - remaining cycles after the first EXEC cycle (LAT-1)
//   dec         - decrement request; ignored once the count is 0
//   zero        - count is 0 (current EXEC cycle is the last one)
module alu_latency_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt;

    // Saturates at 0 so a stray decrement can never wrap to the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: execute-stage controller between the ALU control
// decoder and the ALU datapath. Accepts one decoded op per handshake, holds
// the ALU select/enable for the op's latency, captures the ALU result and
// presents it downstream with a valid/ready handshake.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - decoded op handshake
//   in_alu_op, in_set_nop - op encoding and NOP flag
//   in_rd                 - destination register tag
//   flush                 - kill in-flight or held op (branch redirect)
//   alu_en, alu_op_sel    - ALU control, stable for the whole op
//   alu_result            - ALU output, sampled in the last alu_en cycle
//   out_valid/out_ready   - result handshake
//   out_result, out_rd    - captured result and its tag
//   stall                 - decoder has an op that cannot be taken
//   illegal_op            - one-cycle pulse after a reserved op is consumed
module alu_issue_sequencer
    import alu_issue_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_LATENCY = 1,
    parameter int MUL_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_alu_op,
    input  logic                  in_set_nop,
    input  logic [RD_WIDTH-1:0]   in_rd,
    input  logic                  flush,
    output logic                  alu_en,
    output logic [1:0]            alu_op_sel,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [RD_WIDTH-1:0]   out_rd,
    output logic                  stall,
    output logic                  illegal_op
);

    localparam int CNT_WIDTH = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_WIDTH-1:0] ALU_LOAD = CNT_WIDTH'(ALU_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_LATENCY - 1);

    seq_state_e           state;
    logic [RD_WIDTH-1:0]  pending_rd;
    logic                 accept;
    logic                 issue;
    logic                 cnt_zero;
    logic [CNT_WIDTH-1:0] load_value;

    // A result waiting in DONE blocks new ops until the consumer takes it;
    // taking it and accepting the next op can happen in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            SEQ_IDLE: in_ready = !flush;
            SEQ_EXEC: in_ready = 1'b0;
            SEQ_DONE: in_ready = out_ready && !flush;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign issue      = accept && op_issues(in_alu_op, in_set_nop);
    assign stall      = in_valid && !in_ready;
    assign load_value = (in_alu_op == ALU_OP_MUL) ? MUL_LOAD : ALU_LOAD;

    alu_latency_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_latency_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .load       (issue),
        .load_value (load_value),
        .dec        (state == SEQ_EXEC),
        .zero       (cnt_zero)
    );

    // Sequencer FSM with all outputs registered. flush overrides every
    // transition; out_result/out_rd keep their last value after a flush
    // or a handoff so they only ever change on a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEQ_IDLE;
            alu_en     <= 1'b0;
            alu_op_sel <= '0;
            pending_rd <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= accept && op_illegal(in_alu_op, in_set_nop);
            if (flush) begin
                state     <= SEQ_IDLE;
                alu_en    <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    SEQ_IDLE: begin
                        if (issue) begin
                            state      <= SEQ_EXEC;
                            alu_en     <= 1'b1;
                            alu_op_sel <= in_alu_op;
                            pending_rd <= in_rd;
                        end
                    end
                    SEQ_EXEC: begin
                        if (cnt_zero) begin
                            state      <= SEQ_DONE;
                            alu_en     <= 1'b0;
                            out_valid  <= 1'b1;
                            out_result <= alu_result;
                            out_rd     <= pending_rd;
                        end
                    end
                    SEQ_DONE: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (issue) begin
                                state      <= SEQ_EXEC;
                                alu_en     <= 1'b1;
                                alu_op_sel <= in_alu_op;
                                pending_rd <= in_rd;
                            end else begin
                                state <= SEQ_IDLE;
                            end
                        end
                    end
                    default: begin
                        state  <= SEQ_IDLE;
                        alu_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
